// File: rtl/insn_fetch.sv
// -----------------------------------------------------------------------------
// insn_fetch
//
// Instruction fetch unit. Issues in-order 16-bit reads to instruction memory,
// buffers the returned words in a small prefetch FIFO, and presents the head
// word with its byte address to the decode/execute stage. A redirect pulse
// flushes the FIFO, restarts fetch at the new target and discards every read
// that was already in flight.
//
// Parameters
//   DEPTH     prefetch FIFO entries; also the maximum number of reads in
//             flight (power of 2, >= 2)
//   RESET_IP  first fetch address after reset (bit 0 ignored)
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst_n        in   synchronous active-low reset
//   redirect     in   one-cycle pulse: restart fetch at redirect_ip
//   redirect_ip  in   16  new fetch address, bit 0 forced to 0
//   mem_req      out  read request valid this cycle
//   mem_addr     out  16  byte address of the request (always even)
//   mem_gnt      in   request accepted this cycle (meaningful only with mem_req)
//   mem_rvalid   in   read data valid; responses return in request order
//   mem_rdata    in   16  instruction word
//   insn         out  16  head instruction word
//   insn_ip      out  16  byte address of insn
//   insn_valid   out  head entry valid
//   insn_ready   in   consumer takes the head this cycle when insn_valid
//
// Optional feature (macro INSN_FETCH_BYPASS_EN)
//   When defined, a valid response arriving while the FIFO is empty is shown
//   on insn/insn_ip/insn_valid in the same cycle; if the consumer takes it,
//   it is never written to the FIFO.
//
// Handshakes: a transfer happens on a rising edge where both sides of a pair
// are high -- mem_req/mem_gnt for requests, insn_valid/insn_ready for
// instruction delivery. mem_req and insn_valid never depend on mem_gnt or
// insn_ready respectively; mem_rvalid is a one-way strobe with no back
// pressure, which is why reads are only issued against guaranteed FIFO space.
// -----------------------------------------------------------------------------
module insn_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_ip,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] insn,
  output logic [15:0] insn_ip,
  output logic        insn_valid,
  input  logic        insn_ready
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [15:0] START_IP = RESET_IP & 16'hfffe;

  // Architectural state
  logic [15:0]   fetch_ip;     // address of the next request
  logic [15:0]   resp_ip;      // address owed to the next accepted response
  logic [CW-1:0] count;        // FIFO occupancy
  logic [CW-1:0] outstanding;  // granted reads not yet answered
  logic [CW-1:0] drop;         // stale responses still to be discarded
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   fifo_insn [DEPTH];
  logic [15:0]   fifo_ip   [DEPTH];

  // Per-cycle events
  logic          grant;
  logic          resp;
  logic          resp_drop;
  logic          resp_keep;
  logic          head_valid;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] outstanding_nxt;
  logic [15:0]   target;

  assign target = redirect_ip & 16'hfffe;

  // Every granted read already owns a FIFO slot, so the sum of buffered and
  // in-flight words can never exceed DEPTH and no response is ever refused.
  // Stale in-flight reads still hold their slot until they come back.
  assign used    = {1'b0, count} + {1'b0, outstanding};
  assign mem_req = rst_n && (used < DEPTH_W) && !redirect;
  assign mem_addr = fetch_ip;

  assign grant = mem_req && mem_gnt;

  // A response with nothing outstanding is a protocol violation; it is
  // ignored so that it cannot corrupt the FIFO.
  assign resp      = mem_rvalid && (outstanding != '0);
  assign resp_drop = resp && (drop != '0);
  // A live response in a redirect cycle belongs to the old stream and dies
  // with the flush.
  assign resp_keep = resp && (drop == '0) && !redirect;

  assign head_valid = (count != '0);

  // The flush absorbs a pop that coincides with a redirect.
  assign pop = head_valid && insn_ready && !redirect;

  // Reads in flight after this edge become the discard budget on redirect.
  assign outstanding_nxt = outstanding + CW'(grant) - CW'(resp);

`ifdef INSN_FETCH_BYPASS_EN
  logic byp_hit;

  assign byp_hit = resp_keep && !head_valid;
  // A bypassed word taken by the consumer this cycle never enters the FIFO.
  assign push    = resp_keep && !(byp_hit && insn_ready);

  always_comb begin
    insn_valid = 1'b0;
    insn       = 16'h0000;
    insn_ip    = 16'h0000;
    if (head_valid) begin
      insn_valid = 1'b1;
      insn       = fifo_insn[rd_ptr];
      insn_ip    = fifo_ip[rd_ptr];
    end else if (byp_hit) begin
      insn_valid = 1'b1;
      insn       = mem_rdata;
      insn_ip    = resp_ip;
    end
  end
`else
  assign push = resp_keep;

  always_comb begin
    insn_valid = 1'b0;
    insn       = 16'h0000;
    insn_ip    = 16'h0000;
    if (head_valid) begin
      insn_valid = 1'b1;
      insn       = fifo_insn[rd_ptr];
      insn_ip    = fifo_ip[rd_ptr];
    end
  end
`endif

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Control state. Reset abandons in-flight reads outright: the memory is
  // reset alongside, so no drop budget is carried across it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_ip    <= START_IP;
      resp_ip     <= START_IP;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_ip <= target;
        resp_ip  <= target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        // Recomputed on every redirect, so back-to-back redirects compose.
        drop     <= outstanding_nxt;
      end else begin
        if (grant) begin
          fetch_ip <= fetch_ip + 16'd2;
        end
        if (resp_drop) begin
          drop <= drop - CW'(1);
        end
        // resp_ip tracks every accepted word, bypassed or buffered.
        if (resp_keep) begin
          resp_ip <= resp_ip + 16'd2;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count_nxt;
      end
    end
  end

  // FIFO storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_insn[wr_ptr] <= mem_rdata;
      fifo_ip[wr_ptr]   <= resp_ip;
    end
  end

`ifndef SYNTHESIS
  a_rvalid_with_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n) mem_rvalid |-> (outstanding != '0));

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) (push && !pop) |-> (count != DEPTH_W[CW-1:0]));

  a_addr_even : assert property (
    @(posedge clk) disable iff (!rst_n) mem_req |-> !mem_addr[0]);
`endif

endmodule

// File: tb/tb_insn_fetch.sv
// -----------------------------------------------------------------------------
// tb_insn_fetch
//
// Bench for insn_fetch. A memory responder with programmable latency answers
// granted reads with addr ^ 16'ha5a5. A bench-side model tracks, in terms of
// counts and address streams, how many words are in flight and buffered and
// which instruction stream is current; it predicts mem_req, insn_valid, the
// head word and each request address every cycle. Directed phases cover
// reset, back-pressure, stale-response discarding, address wrap, a redirect
// colliding with a pop and a response, and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_insn_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_IP = 16'h0000;
`ifdef INSN_FETCH_BYPASS_EN
  localparam bit BYP     = 1'b1;
  localparam int EXP_LAT = 2;
`else
  localparam bit BYP     = 1'b0;
  localparam int EXP_LAT = 3;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_ip;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] insn;
  logic [15:0] insn_ip;
  logic        insn_valid;
  logic        insn_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  insn_fetch #(.DEPTH(DEPTH), .RESET_IP(RESET_IP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_ip (redirect_ip),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .insn        (insn),
    .insn_ip     (insn_ip),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];     // expected {insn_ip, insn} stream
  logic [15:0] log_ip[$];    // consumed words, as seen on the DUT outputs
  logic [15:0] log_ins[$];

  // Model state
  int          m_inflight = 0;  // granted, not yet answered (stale included)
  int          m_fifo     = 0;  // words of the current stream held for consumer
  int          epoch      = 0;  // stream generation, bumped by redirect/reset
  logic [15:0] m_fetch    = RESET_IP & 16'hfffe;
  int          n_grant    = 0;

  // Memory responder knobs, set by the stimulus
  int lat    = 1;
  bit gnt_en = 1'b1;

  typedef struct {
    int          due;
    logic [15:0] addr;
    int          ep;
  } req_t;
  req_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_exp(input logic [15:0] start);
    logic [15:0] a;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({a, a ^ 16'ha5a5});
      a = a + 16'd2;
    end
  endtask

  function automatic logic [15:0] qget(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 16'hxxxx;
  endfunction

  // Memory responder + per-cycle compare. Inputs change at the falling edge,
  // outputs are compared 2 time units later, and the model then advances as
  // the DUT will at the next rising edge.
  initial begin : monitor
    req_t        e;
    int          cur_ep;
    bit          exp_req, exp_valid, live, byp_hit, consumed, grant, push, pop;
    logic [31:0] head;
    logic        r, rdy, rst;
    logic [15:0] rip;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    fill_exp(RESET_IP & 16'hfffe);
    forever begin
      @(negedge clk);
      cyc++;
      cur_ep = -1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        e          = mq.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = e.addr ^ 16'ha5a5;
        cur_ep     = e.ep;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
      end
      mem_gnt = gnt_en;
      #2;
      r   = redirect;
      rip = redirect_ip;
      rdy = insn_ready;
      rst = rst_n;

      exp_req = rst && (DEPTH - m_inflight - m_fifo > 0) && !r;
      chk("mem_req", 32'(mem_req), 32'(exp_req));

      if (!rst) begin
        m_inflight = 0;
        m_fifo     = 0;
        mq.delete();
        epoch++;
        m_fetch = RESET_IP & 16'hfffe;
        fill_exp(RESET_IP & 16'hfffe);
        continue;
      end

      live      = mem_rvalid && (cur_ep == epoch);
      byp_hit   = BYP && (m_fifo == 0) && live && !r;
      exp_valid = (m_fifo > 0) || byp_hit;
      chk("insn_valid", 32'(insn_valid), 32'(exp_valid));
      head = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
      if (exp_valid) begin
        chk("insn_ip", 32'(insn_ip), 32'(head[31:16]));
        chk("insn", 32'(insn), 32'(head[15:0]));
      end

      grant = exp_req && mem_gnt;
      if (grant) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_fetch));
        mq.push_back('{cyc + lat, mem_addr, epoch});
        m_fetch = m_fetch + 16'd2;
        n_grant++;
      end
      if (mem_rvalid) m_inflight--;
      if (grant) m_inflight++;

      if (r) begin
        epoch++;
        m_fifo  = 0;
        m_fetch = rip & 16'hfffe;
        fill_exp(rip & 16'hfffe);
      end else begin
        consumed = exp_valid && rdy;
        push     = live && !(byp_hit && rdy);
        pop      = consumed && (m_fifo > 0);
        m_fifo   = m_fifo + int'(push) - int'(pop);
        if (consumed) begin
          log_ip.push_back(insn_ip);
          log_ins.push_back(insn);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  // Counts cycles after a redirect/reset cycle until insn_valid, starting at
  // offset k0; returns 99 if the bound expires.
  task automatic wait_valid(input int k0, output int n);
    n = 99;
    for (int k = k0; k <= 20; k++) begin
      @(negedge clk);
      redirect = 1'b0;
      rst_n    = 1'b1;
      #3;
      if (insn_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic clear_log();
    log_ip.delete();
    log_ins.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : stimulus
    int n;
    int base;
    bit found;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_ip = 16'h0000;
    insn_ready  = 1'b1;

    // Reset values, then the first word 3 cycles after the last reset cycle.
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_insn_valid", 32'(insn_valid), 32'h0);
    chk("rst_insn", 32'(insn), 32'h0);
    chk("rst_insn_ip", 32'(insn_ip), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    clear_log();
    wait_valid(1, n);
    chk("reset_to_valid", 32'(n), 32'(EXP_LAT));
    repeat (12) @(negedge clk);
    chk("seq_ip0", 32'(qget(log_ip, 0)), 32'h0000);
    chk("seq_ip1", 32'(qget(log_ip, 1)), 32'h0002);
    chk("seq_ip2", 32'(qget(log_ip, 2)), 32'h0004);
    chk("seq_ins0", 32'(qget(log_ins, 0)), 32'ha5a5);
    chk("seq_ins1", 32'(qget(log_ins, 1)), 32'ha5a7);
    chk("seq_ins2", 32'(qget(log_ins, 2)), 32'ha5a1);

    // Consumer stalls for 10 cycles: fetch must stop once DEPTH words are owed.
    @(negedge clk);
    insn_ready = 1'b0;
    base = n_grant;
    repeat (9) @(negedge clk);
    #3;
    chk("stall_mem_req", 32'(mem_req), 32'h0);
    chk("stall_grants_le_depth", 32'((n_grant - base) <= DEPTH), 32'h1);
    @(negedge clk);
    insn_ready = 1'b1;
    repeat (12) @(negedge clk);

    // 3-cycle memory, redirect to an odd target with two reads in flight.
    lat   = 3;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (m_inflight == 2) begin
        redirect    = 1'b1;
        redirect_ip = 16'h1235;
        clear_log();
        found = 1'b1;
        break;
      end
    end
    chk("two_in_flight_seen", 32'(found), 32'h1);
    @(negedge clk);
    redirect = 1'b0;
    repeat (19) @(negedge clk);
    chk("redir_ip0", 32'(qget(log_ip, 0)), 32'h1234);
    chk("redir_ins0", 32'(qget(log_ins, 0)), 32'hb791);

    // Drain, then redirect near the top of memory: address wrap and latency.
    @(negedge clk);
    gnt_en = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    gnt_en      = 1'b1;
    lat         = 1;
    redirect    = 1'b1;
    redirect_ip = 16'hfffc;
    clear_log();
    wait_valid(1, n);
    chk("redirect_to_valid", 32'(n), 32'(EXP_LAT));
    repeat (8) @(negedge clk);
    chk("wrap_ip0", 32'(qget(log_ip, 0)), 32'hfffc);
    chk("wrap_ip1", 32'(qget(log_ip, 1)), 32'hfffe);
    chk("wrap_ip2", 32'(qget(log_ip, 2)), 32'h0000);
    chk("wrap_ins0", 32'(qget(log_ins, 0)), 32'h5a59);
    chk("wrap_ins2", 32'(qget(log_ins, 2)), 32'ha5a5);

    // Redirect in a cycle with a buffered head being popped and a live
    // response arriving.
    @(negedge clk);
    insn_ready = 1'b0;
    @(negedge clk);
    insn_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (mem_rvalid && m_fifo > 0) begin
        redirect    = 1'b1;
        redirect_ip = 16'h0400;
        clear_log();
        found = 1'b1;
        break;
      end
    end
    chk("collision_seen", 32'(found), 32'h1);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    chk("post_collision_valid", 32'(insn_valid), 32'h0);
    repeat (10) @(negedge clk);
    chk("collision_ip0", 32'(qget(log_ip, 0)), 32'h0400);
    chk("collision_ins0", 32'(qget(log_ins, 0)), 32'ha1a5);

    // One-cycle reset mid-stream.
    repeat (5) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    clear_log();
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("mid_rst_insn_valid", 32'(insn_valid), 32'h0);
    chk("mid_rst_insn", 32'(insn), 32'h0);
    chk("mid_rst_insn_ip", 32'(insn_ip), 32'h0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'h1);
    wait_valid(2, n);
    chk("mid_rst_to_valid", 32'(n), 32'(EXP_LAT));
    repeat (6) @(negedge clk);
    chk("mid_rst_ip0", 32'(qget(log_ip, 0)), 32'h0000);
    chk("mid_rst_ins0", 32'(qget(log_ins, 0)), 32'ha5a5);

    // ---------------------------------------------------------------- report
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #50000;
    n_fail++;
    $display("FAIL watchdog: simulation time %0t, expected completion before 50000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Instruction fetch unit that feeds 16-bit instruction words, with their addresses, to the decoder/execute stage.
- Issues in-order read requests to instruction memory and buffers the returned words in a small prefetch FIFO.
- Handles redirects, driven by the execute stage when `load_ip` fires: flushes buffered words and discards stale in-flight responses.

Parameters:
- DEPTH, 2, prefetch FIFO entries; also the maximum number of outstanding memory reads (power of 2, ≥2).
- RESET_IP, 16'h0000, first fetch address after reset (bit 0 ignored).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- redirect  in  1  one-cycle pulse: restart fetch at redirect_ip
- redirect_ip  in  16  new fetch address; bit 0 forced to 0
- mem_req  out  1  read request valid this cycle
- mem_addr  out  16  byte address of request, always even
- mem_gnt  in  1  request accepted this cycle (valid only with mem_req)
- mem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant
- mem_rdata  in  16  instruction word
- insn  out  16  head instruction word
- insn_ip  out  16  byte address of insn
- insn_valid  out  1  head entry valid
- insn_ready  in  1  consumer takes head this cycle when insn_valid

Behaviour:
- Reset (rst_n=0 at edge):
  - fetch pointer = RESET_IP & 16'hfffe; FIFO empty; outstanding=0; drop=0.
  - Outputs: mem_req=0, mem_addr=RESET_IP&16'hfffe, insn_valid=0, insn=0, insn_ip=0.
  - Reset mid-operation abandons all in-flight reads. Responses arriving after reset release are not counted by drop and are buffered as if valid; this is a system-level reset requirement, with memory reset alongside.
- Credit:
  - credit = DEPTH − occupancy − outstanding.
  - mem_req = (credit>0) && !redirect, registered-free (combinational from state and redirect).
  - Request is per-cycle. No stickiness required; a deasserted request without grant is simply not issued.
- Grant (mem_req && mem_gnt): outstanding+1, fetch pointer += 2. Wraps 16'hfffe → 16'h0000.
- Response (mem_rvalid):
  - outstanding−1.
  - If drop>0: drop−1, word discarded.
  - Otherwise push {mem_rdata, resp_ip} into FIFO. resp_ip is a separate counter advanced by 2 per accepted response.
- Pop (insn_valid && insn_ready): head removed.
- Push and pop in the same cycle is legal at any occupancy; credit guarantees no overflow.
- FIFO write is visible on insn_valid the next cycle; no bypass (see option).
- Redirect cycle:
  - mem_req=0.
  - FIFO flushed at the edge; a simultaneous pop is absorbed by the flush.
  - drop_next = outstanding_next (excluding the discarded response of this cycle).
  - A grant this cycle is impossible (mem_req=0).
  - fetch pointer = resp_ip = redirect_ip & 16'hfffe.
- Back-to-back redirects: the later one wins; drop is recomputed each time.
- Latency, redirect at cycle t, 1-cycle memory: mem_req with new addr at t+1, gnt t+1, rvalid t+2, insn_valid t+3.
- Sustained throughput: one insn/cycle when memory grants every cycle with 1-cycle latency and DEPTH≥2.
- Protocol error: mem_rvalid with outstanding=0 is a protocol error; assertion in simulation, otherwise ignored.

Optional Feature:
- Macro: INSN_FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a valid (non-dropped) response arrives, insn/insn_ip/insn_valid reflect mem_rdata combinationally that cycle.
  - If insn_ready=1 the word is consumed without a FIFO write; otherwise it is written.
  - Redirect-to-valid latency becomes t+2.
  - Redirect in the same cycle as the response forces insn_valid=0.
- Undefined: all outputs registered from FIFO as above.

Test Plan:
- Reset, memory grants every cycle, rdata=addr^16'ha5a5, insn_ready=1 -> insn_ip sequence 0,2,4,6…, insn=16'ha5a5,16'ha5a7…, first insn_valid 3 cycles after reset release, then one per cycle.
- insn_ready=0 for 10 cycles -> at most DEPTH grants issued, mem_req=0 thereafter, no lost/duplicated word on release.
- Memory latency 3 cycles, redirect to 16'h1235 with 2 reads outstanding -> both stale responses dropped, next insn_ip=16'h1234, mem_addr never odd.
- Fetch from 16'hfffc continuous -> insn_ip 16'hfffc,16'hfffe,16'h0000 (wrap).
- Redirect coincident with pop and with a response arrival -> FIFO empty next cycle, stale response dropped, no insn_valid until new-target data.
- Mid-stream rst_n=0 for 1 cycle -> all outputs at reset values next cycle, fetch restarts at RESET_IP; with INSN_FETCH_BYPASS_EN, redirect-to-insn_valid measured as 2 cycles.
